// File: rtl/rtl_bigreg_publisher_pkg.sv
// ----------------------------------------------------------------------------
// rtl_bigreg_publisher_pkg
//   Shared definitions for the RTL_BIGREG publisher: the mem_map layout used
//   by the default parameterisation (buffer timestamp block) and the
//   publisher FSM state type.
// ----------------------------------------------------------------------------
package rtl_bigreg_publisher_pkg;

    localparam int BUFF_TIMESTAMP_WIDTH = 32;
    localparam int WD_DATA_WIDTH        = 16;
    localparam int MEM_MAP_SIZE         = 256;
    localparam int BUFF_SAMPLES         = BUFF_TIMESTAMP_WIDTH / WD_DATA_WIDTH;
    localparam int BUFF_TIME_BASE_ID    = 27;
    localparam int BUFF_TIME_VALID_ID   = BUFF_TIME_BASE_ID + BUFF_SAMPLES;

    typedef enum logic [2:0] {
        BP_IDLE,
        BP_WRITE,
        BP_SETV,
        BP_WAIT,
        BP_CLRV
    } bigreg_pub_state_t;

endpackage

// File: rtl/rtl_bigreg_publisher_if.sv
// ----------------------------------------------------------------------------
// rtl_bigreg_publisher_if
//   Bundles the publisher's value handshake, the mem_map write port and the
//   PS read notification.
//   master : the publisher (drives bigreg_ready, mem_*, pending, overwrite_cnt)
//   slave  : the environment (drives bigreg_in/valid, mem_wready, ps_valid_read)
// ----------------------------------------------------------------------------
interface rtl_bigreg_publisher_if
    import rtl_bigreg_publisher_pkg::*;
#(
    parameter int DATA_WIDTH = BUFF_TIMESTAMP_WIDTH,
    parameter int WORD_WIDTH = WD_DATA_WIDTH,
    parameter int ID_W       = $clog2(MEM_MAP_SIZE)
);
    logic [DATA_WIDTH-1:0] bigreg_in;
    logic                  bigreg_valid;
    logic                  bigreg_ready;
    logic                  mem_wen;
    logic [ID_W-1:0]       mem_id;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_wready;
    logic                  ps_valid_read;
    logic                  pending;
    logic [15:0]           overwrite_cnt;

    modport master (
        input  bigreg_in, bigreg_valid, mem_wready, ps_valid_read,
        output bigreg_ready, mem_wen, mem_id, mem_wdata, pending, overwrite_cnt
    );

    modport slave (
        output bigreg_in, bigreg_valid, mem_wready, ps_valid_read,
        input  bigreg_ready, mem_wen, mem_id, mem_wdata, pending, overwrite_cnt
    );
endinterface

// File: rtl/rtl_bigreg_publisher.sv
// ----------------------------------------------------------------------------
// rtl_bigreg_publisher
//   Publishes one wide value into consecutive mem_map entries
//   BASE_ID..BASE_ID+SAMPLES-1 (low word first), then sets VALID_ID to 1.
//   After the PS reports reading VALID_ID, VALID_ID is written back to 0 and
//   the next value is accepted.
//
// Ports
//   clk   in  system clock
//   rst   in  asynchronous reset, active-high
//   bus   rtl_bigreg_publisher_if.master
//         bigreg_in/bigreg_valid/bigreg_ready : value handshake
//         mem_wen/mem_id/mem_wdata/mem_wready : mem_map write port
//         ps_valid_read : PS finished reading VALID_ID (1-cycle pulse)
//         pending       : a published value is still unread
//         overwrite_cnt : unread values that were replaced
//
// Build option
//   BIGREG_OVERWRITE_EN : when defined, a new value may be taken while the
//   previous one is still unread; VALID_ID is cleared, the words rewritten
//   and VALID_ID set again. When undefined, overwrite_cnt stays 0 and new
//   values are back-pressured until the PS read has been acknowledged.
// ----------------------------------------------------------------------------
module rtl_bigreg_publisher
    import rtl_bigreg_publisher_pkg::*;
#(
    parameter int DATA_WIDTH = BUFF_TIMESTAMP_WIDTH,
    parameter int WORD_WIDTH = WD_DATA_WIDTH,
    parameter int MEM_SIZE   = MEM_MAP_SIZE,
    parameter int BASE_ID    = BUFF_TIME_BASE_ID
) (
    input  logic                          clk,
    input  logic                          rst,
    rtl_bigreg_publisher_if.master        bus
);

    localparam int SAMPLES = DATA_WIDTH / WORD_WIDTH;
    localparam int ID_W    = $clog2(MEM_SIZE);
    localparam int K_W     = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic [ID_W-1:0] BASE_IDV  = ID_W'(BASE_ID);
    localparam logic [ID_W-1:0] VALID_IDV = ID_W'(BASE_ID + SAMPLES);
    localparam logic [K_W-1:0]  LAST_K    = K_W'(SAMPLES - 1);

`ifdef BIGREG_OVERWRITE_EN
    localparam bit OVERWRITE_EN = 1'b1;
`else
    localparam bit OVERWRITE_EN = 1'b0;
`endif

    generate
        if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_split
            $error("DATA_WIDTH must be a multiple of WORD_WIDTH");
        end
        if (BASE_ID + SAMPLES >= MEM_SIZE) begin : g_bad_range
            $error("BASE_ID+SAMPLES must lie inside the mem_map");
        end
    endgenerate

    function automatic logic [WORD_WIDTH-1:0] word_sel(input logic [DATA_WIDTH-1:0] v,
                                                       input logic [K_W-1:0]        idx);
        return WORD_WIDTH'(v >> (int'(idx) * WORD_WIDTH));
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    bigreg_pub_state_t     state;
    logic [DATA_WIDTH-1:0] shadow;
    logic [K_W-1:0]        k;
    logic [K_W-1:0]        k_inc;
    logic                  ret_write;   // CLRV continues into WRITE (overwrite path)
    logic                  ready_q;
    logic                  wen_q;
    logic [ID_W-1:0]       id_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  pending_q;
    logic [15:0]           ocnt_q;
    logic                  beat;

    assign k_inc = k + K_W'(1);
    assign beat  = wen_q && bus.mem_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BP_IDLE;
            shadow    <= '0;
            k         <= '0;
            ret_write <= 1'b0;
            ready_q   <= 1'b1;
            wen_q     <= 1'b0;
            id_q      <= '0;
            wdata_q   <= '0;
            pending_q <= 1'b0;
            ocnt_q    <= '0;
        end else begin
            case (state)
                BP_IDLE: begin
                    if (bus.bigreg_valid) begin
                        shadow  <= bus.bigreg_in;
                        k       <= '0;
                        ready_q <= 1'b0;
                        wen_q   <= 1'b1;
                        id_q    <= BASE_IDV;
                        wdata_q <= word_sel(bus.bigreg_in, '0);
                        state   <= BP_WRITE;
                    end
                end
                BP_WRITE: begin
                    if (beat) begin
                        if (k == LAST_K) begin
                            id_q    <= VALID_IDV;
                            wdata_q <= WORD_WIDTH'(1);
                            state   <= BP_SETV;
                        end else begin
                            k       <= k_inc;
                            id_q    <= BASE_IDV + ID_W'(k_inc);
                            wdata_q <= word_sel(shadow, k_inc);
                        end
                    end
                end
                BP_SETV: begin
                    // A PS read in this cycle is ignored: valid=1 is not visible yet.
                    if (beat) begin
                        wen_q     <= 1'b0;
                        pending_q <= 1'b1;
                        ready_q   <= OVERWRITE_EN;
                        state     <= BP_WAIT;
                    end
                end
                BP_WAIT: begin
                    // A new value takes priority over a simultaneous PS read.
                    if (OVERWRITE_EN && bus.bigreg_valid) begin
                        shadow    <= bus.bigreg_in;
                        k         <= '0;
                        ocnt_q    <= sat_inc16(ocnt_q);
                        ret_write <= 1'b1;
                        ready_q   <= 1'b0;
                        wen_q     <= 1'b1;
                        id_q      <= VALID_IDV;
                        wdata_q   <= '0;
                        state     <= BP_CLRV;
                    end else if (bus.ps_valid_read) begin
                        ret_write <= 1'b0;
                        ready_q   <= 1'b0;
                        wen_q     <= 1'b1;
                        id_q      <= VALID_IDV;
                        wdata_q   <= '0;
                        state     <= BP_CLRV;
                    end
                end
                BP_CLRV: begin
                    if (beat) begin
                        if (ret_write) begin
                            id_q    <= BASE_IDV;
                            wdata_q <= word_sel(shadow, '0);
                            state   <= BP_WRITE;
                        end else begin
                            wen_q     <= 1'b0;
                            pending_q <= 1'b0;
                            ready_q   <= 1'b1;
                            state     <= BP_IDLE;
                        end
                    end
                end
                default: begin
                    wen_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= BP_IDLE;
                end
            endcase
        end
    end

    assign bus.bigreg_ready  = ready_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_id        = id_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.pending       = pending_q;
    assign bus.overwrite_cnt = ocnt_q;

endmodule

// File: tb/tb_rtl_bigreg_publisher.sv
// ----------------------------------------------------------------------------
// tb_rtl_bigreg_publisher
//   Self-checking bench for rtl_bigreg_publisher (default parameterisation).
//   Expected mem_map beats are derived from each accepted value and each
//   acknowledged PS read and compared in order against the beats observed.
//   Honours BIGREG_OVERWRITE_EN when defined.
// ----------------------------------------------------------------------------
module tb_rtl_bigreg_publisher;
    import rtl_bigreg_publisher_pkg::*;

    localparam int         S    = BUFF_SAMPLES;
    localparam int         BASE = BUFF_TIME_BASE_ID;
    localparam logic [7:0] VID  = 8'(BUFF_TIME_VALID_ID);
`ifdef BIGREG_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtl_bigreg_publisher_if bus ();

    rtl_bigreg_publisher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] exp_q[$];
    bit          m_outstanding = 1'b0;
    logic [15:0] m_ocnt = 16'd0;

    function automatic void model_transfer(input logic [31:0] v);
        if (OVW && m_outstanding) begin
            exp_q.push_back({VID, 16'h0000});
            if (m_ocnt != 16'hFFFF) m_ocnt = m_ocnt + 16'd1;
        end
        for (int i = 0; i < S; i++) exp_q.push_back({8'(BASE + i), v[i*16 +: 16]});
        exp_q.push_back({VID, 16'h0001});
        m_outstanding = 1'b1;
    endfunction

    // ---------------- mem_wready driver ----------------
    int wr_mode   = 0;   // 0: always ready, 1: random, 2: stall word 28 three times
    int stall_cnt = 0;
    initial begin
        bus.mem_wready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (wr_mode)
                1: bus.mem_wready = ($urandom_range(0, 3) != 0);
                2: if (bus.mem_wen && bus.mem_id == 8'(BASE + 1) && stall_cnt < 3) begin
                       bus.mem_wready = 1'b0;
                       stall_cnt++;
                   end else bus.mem_wready = 1'b1;
                default: bus.mem_wready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor (sampled mid-cycle) ----------------
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_id;
    logic [15:0] prev_data;
    logic [23:0] e;
    int          hold28 = 0;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_val("hold_wen", 64'(bus.mem_wen), 64'(1));
                check_val("hold_id", 64'(bus.mem_id), 64'(prev_id));
                check_val("hold_data", 64'(bus.mem_wdata), 64'(prev_data));
            end
            hold_prev = bus.mem_wen && !bus.mem_wready;
            prev_id   = bus.mem_id;
            prev_data = bus.mem_wdata;
            if (bus.bigreg_valid && bus.bigreg_ready) model_transfer(bus.bigreg_in);
            if (bus.mem_wen && bus.mem_wready) begin
                if (exp_q.size() == 0) check_val("beat_unexpected", 64'(exp_q.size()), 64'(1));
                else begin
                    e = exp_q.pop_front();
                    check_val("beat", 64'({bus.mem_id, bus.mem_wdata}), 64'(e));
                end
            end
            if (wr_mode == 2 && bus.mem_wen && bus.mem_id == 8'(BASE + 1)) hold28++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic publish(input logic [31:0] v);
        int c = 0;
        while (bus.bigreg_ready !== 1'b1 && c < 100) begin step(1); c++; end
        check_val("ready_before_publish", 64'(bus.bigreg_ready), 64'(1));
        bus.bigreg_in    = v;
        bus.bigreg_valid = 1'b1;
        step(1);
        bus.bigreg_valid = 1'b0;
        bus.bigreg_in    = $urandom();   // must not affect the value in flight
    endtask

    task automatic ps_read(input bit effective);
        if (effective) begin
            exp_q.push_back({VID, 16'h0000});
            m_outstanding = 1'b0;
        end
        bus.ps_valid_read = 1'b1;
        step(1);
        bus.ps_valid_read = 1'b0;
    endtask

    task automatic wait_pending(input logic exp, input int bound, output int cyc);
        cyc = 0;
        while (bus.pending !== exp && cyc < bound) begin step(1); cyc++; end
        check_val("pending_reached", 64'(bus.pending), 64'(exp));
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin step(1); c++; end
        check_val("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    int cyc;
    initial begin
        rst               = 1'b1;
        bus.bigreg_in     = '0;
        bus.bigreg_valid  = 1'b0;
        bus.ps_valid_read = 1'b0;
        step(2);
        check_val("rst_ready", 64'(bus.bigreg_ready), 64'(1));
        check_val("rst_wen", 64'(bus.mem_wen), 64'(0));
        check_val("rst_id", 64'(bus.mem_id), 64'(0));
        check_val("rst_wdata", 64'(bus.mem_wdata), 64'(0));
        check_val("rst_pending", 64'(bus.pending), 64'(0));
        check_val("rst_ocnt", 64'(bus.overwrite_cnt), 64'(0));
        rst = 1'b0;
        step(1);

        // Test 1: basic publish, latency of pending
        publish(32'hDEAD_BEEF);
        check_val("t1_first_id", 64'(bus.mem_id), 64'(BASE));
        wait_pending(1'b1, 50, cyc);
        check_val("t1_latency", 64'(cyc), 64'(S + 1));
        check_val("t1_ready", 64'(bus.bigreg_ready), 64'(OVW));
        drain();

        // Test 2: PS read clears VALID_ID and reopens the input
        ps_read(1'b1);
        wait_pending(1'b0, 50, cyc);
        check_val("t2_clear_latency", 64'(cyc), 64'(1));
        check_val("t2_ready", 64'(bus.bigreg_ready), 64'(1));
        drain();

        // Test 3: stalled write on word 28
        stall_cnt = 0; hold28 = 0; wr_mode = 2;
        publish(32'hDEAD_BEEF);
        wait_pending(1'b1, 50, cyc);
        check_val("t3_hold_cycles", 64'(hold28), 64'(4));
        check_val("t3_stalls", 64'(stall_cnt), 64'(3));
        wr_mode = 0;
        ps_read(1'b1);
        wait_pending(1'b0, 50, cyc);
        drain();

        // Test 4: second value while waiting for the PS
        publish(32'hCAFE_0042);
        wait_pending(1'b1, 50, cyc);
        drain();
        if (OVW) begin
            publish(32'h1234_5678);
            drain();
            check_val("t4_pending_kept", 64'(bus.pending), 64'(1));
            check_val("t4_ocnt", 64'(bus.overwrite_cnt), 64'(m_ocnt));
        end else begin
            bus.bigreg_in    = 32'h1234_5678;
            bus.bigreg_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                check_val("t4_backpressure", 64'(bus.bigreg_ready), 64'(0));
                step(1);
            end
            bus.bigreg_valid = 1'b0;
            check_val("t4_no_writes", 64'(exp_q.size()), 64'(0));
            check_val("t4_ocnt", 64'(bus.overwrite_cnt), 64'(0));
        end
        ps_read(1'b1);
        wait_pending(1'b0, 50, cyc);
        drain();

        // Test 5: reset in the middle of the word writes
        publish(32'hA5A5_5A5A);
        step(1);
        check_val("t5_at_k1", 64'(bus.mem_id), 64'(BASE + 1));
        rst = 1'b1;
        exp_q.delete();
        m_outstanding = 1'b0;
        m_ocnt        = 16'd0;
        #1;
        check_val("t5_rst_wen", 64'(bus.mem_wen), 64'(0));
        check_val("t5_rst_id", 64'(bus.mem_id), 64'(0));
        check_val("t5_rst_wdata", 64'(bus.mem_wdata), 64'(0));
        check_val("t5_rst_ready", 64'(bus.bigreg_ready), 64'(1));
        check_val("t5_rst_pending", 64'(bus.pending), 64'(0));
        step(2);
        rst = 1'b0;
        step(1);
        publish(32'h0000_0001);
        check_val("t5_restart_id", 64'(bus.mem_id), 64'(BASE));
        wait_pending(1'b1, 50, cyc);
        check_val("t5_latency", 64'(cyc), 64'(S + 1));
        ps_read(1'b1);
        wait_pending(1'b0, 50, cyc);
        drain();

        // Test 6: stray PS reads in IDLE and in the SETV cycle are ignored
        ps_read(1'b0);
        step(2);
        check_val("t6_idle_pending", 64'(bus.pending), 64'(0));
        check_val("t6_idle_wen", 64'(bus.mem_wen), 64'(0));
        publish(32'h0BAD_F00D);
        step(S);
        check_val("t6_setv_id", 64'(bus.mem_id), 64'(VID));
        check_val("t6_setv_data", 64'(bus.mem_wdata), 64'(1));
        ps_read(1'b0);
        check_val("t6_pending_up", 64'(bus.pending), 64'(1));
        step(4);
        check_val("t6_pending_held", 64'(bus.pending), 64'(1));
        check_val("t6_no_clear", 64'(bus.mem_wen), 64'(0));
        ps_read(1'b1);
        wait_pending(1'b0, 50, cyc);
        drain();

        // Randomized traffic with random write back-pressure and read delay
        wr_mode = 1;
        for (int n = 0; n < 16; n++) begin
            publish($urandom());
            wait_pending(1'b1, 200, cyc);
            step($urandom_range(0, 4));
            check_val("rnd_pending", 64'(bus.pending), 64'(1));
            ps_read(1'b1);
            wait_pending(1'b0, 200, cyc);
            check_val("rnd_ready", 64'(bus.bigreg_ready), 64'(1));
        end
        wr_mode = 0;
        drain();
        check_val("final_ocnt", 64'(bus.overwrite_cnt), 64'(m_ocnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
